// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store initiator between the MEM stage and a word-organised memory port
module lsu_master #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            state;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              access;
    logic              is_byte;
    logic              is_half;
    logic              aligned;
    logic              start;
    logic [3:0]        be_n;
    logic [DATA_W-1:0] wdata_n;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_fmt;

    // Size comes from Funct3[1:0]; codes 011/110/111 fall through to word.
    assign access  = MemRead | MemWrite;
    assign is_byte = (Funct3[1:0] == 2'b00);
    assign is_half = (Funct3[1:0] == 2'b01);
    assign aligned = is_byte
                   | (is_half & ~a[0])
                   | (~is_byte & ~is_half & (a[1:0] == 2'b00));

    assign start      = rst_n && (state == IDLE) && access && aligned;
    assign stall      = start || (rst_n && (state == REQ));
    assign misaligned = rst_n && (state == IDLE) && access && !aligned;

    always_comb begin
        be_n    = 4'b0000;
        wdata_n = '0;
        if (!MemRead) begin
            if (is_byte) begin
                be_n    = 4'b0001 << a[1:0];
                wdata_n = {4{wd[7:0]}};
            end else if (is_half) begin
                be_n    = 4'b0011 << a[1:0];
                wdata_n = {2{wd[15:0]}};
            end else begin
                be_n    = 4'b1111;
                wdata_n = wd;
            end
        end
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_fmt = shifted;
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_fmt = {24'b0, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_fmt = {16'b0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
            mem_addr  <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ~MemRead;
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                            mem_addr  <= {a[DM_ADDRESS-1:2], 2'b00};
                            f3_q      <= Funct3;
                            off_q     <= a[1:0];
                        end else begin
                            rd <= '0;
                        end
                    end
                end
                REQ: begin
                    // mem_* stay frozen until the ack; only the read path updates rd.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rd <= load_fmt;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - self-checking bench for lsu_master
module tb_lsu_master;

    logic        clk;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall, misaligned;
    logic        mem_req, mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 0;
    logic        e_stall, e_mis, e_req, e_we;
    logic [8:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rd;
    int          stall_cnt = 0;
    logic        seen_we;
    logic [8:0]  seen_addr;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;

    lsu_master #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .a(a), .wd(wd), .rd(rd), .stall(stall),
        .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit m_aligned(input logic [2:0] f3, input logic [8:0] addr);
        return (int'(addr) % sz(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [8:0] addr,
                                           input logic [31:0] word);
        int     n    = sz(f3);
        int     off  = int'(addr) % 4;
        longint full = longint'(1) << (8 * n);
        longint v    = {32'b0, word};
        v = (v >> (8 * off)) % full;
        if (f3[2] == 1'b0 && n < 4 && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [8:0] addr);
        int n = sz(f3);
        return 4'(((1 << n) - 1) << (int'(addr) % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] r;
        int n = sz(f3);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = data[8*(k % n) +: 8];
        return r;
    endfunction

    task compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("stall", stall, e_stall);
                chk("misaligned", misaligned, e_mis);
                chk("mem_req", mem_req, e_req);
                chk("rd", rd, e_rd);
                if (e_req) begin
                    chk("mem_we", mem_we, e_we);
                    chk("mem_addr", mem_addr, e_addr);
                    chk("mem_be", mem_be, e_be);
                    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
                    seen_we    = mem_we;
                    seen_addr  = mem_addr;
                    seen_be    = mem_be;
                    seen_wdata = mem_wdata;
                end
                if (stall) stall_cnt++;
            end
        end
    endtask

    task automatic access(input bit r, input bit w, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] wdv, input logic [31:0] rdv, input int wait_n);
        bit al = m_aligned(f3, addr);
        int base;
        @(posedge clk); #1;
        MemRead = r; MemWrite = w; Funct3 = f3; a = addr; wd = wdv;
        mem_ack = 0; mem_rdata = ~rdv;
        e_req = 0; e_mis = !al; e_stall = al; base = stall_cnt; chk_en = 1;
        if (!al) begin
            @(posedge clk); #1;
            MemRead = 0; MemWrite = 0;
            e_rd = 0; e_mis = 0; e_stall = 0;
            @(negedge clk); #1;
            chk("stall_cycles", stall_cnt - base, 0);
            return;
        end
        e_we = !r; e_addr = {addr[8:2], 2'b00};
        e_be = r ? 4'b0000 : m_be(f3, addr);
        e_wdata = m_wdata(f3, wdv);
        for (int i = 0; i <= wait_n; i++) begin
            @(posedge clk); #1;
            a = 9'($urandom); wd = $urandom;
            mem_ack = (i == wait_n);
            mem_rdata = mem_ack ? rdv : $urandom;
            e_req = 1; e_stall = 1; e_mis = 0;
        end
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0; mem_ack = 0;
        if (r) e_rd = m_load(f3, addr, rdv);
        e_req = 0; e_stall = 0;
        @(negedge clk); #1;
        chk("stall_cycles", stall_cnt - base, 2 + wait_n);
    endtask

    initial begin
        fork
            compare_loop();
        join_none
        rst_n = 0; MemRead = 0; MemWrite = 0; Funct3 = 0; a = 0; wd = 0;
        mem_rdata = 0; mem_ack = 0;
        e_stall = 0; e_mis = 0; e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_rd = 0;
        #12;
        chk("reset_rd", rd, 0);
        chk("reset_req", mem_req, 0);
        chk("reset_we", mem_we, 0);
        chk("reset_be", mem_be, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_mis", misaligned, 0);
        chk("reset_stall", stall, 0);
        @(negedge clk); rst_n = 1;

        access(0, 1, 3'b000, 9'h013, 32'h000000AB, 32'h0, 0);
        chk("sb_addr", seen_addr, 9'h010);
        chk("sb_be", seen_be, 4'b1000);
        chk("sb_wdata", seen_wdata, 32'hABABABAB);
        chk("sb_we", seen_we, 1);

        access(1, 0, 3'b000, 9'h002, 32'h0, 32'h1180FF00, 0);
        chk("lb_rd", rd, 32'hFFFFFF80);
        access(1, 0, 3'b100, 9'h002, 32'h0, 32'h1180FF00, 0);
        chk("lbu_rd", rd, 32'h00000080);
        access(1, 0, 3'b001, 9'h002, 32'h0, 32'h80011234, 0);
        chk("lh_rd", rd, 32'hFFFF8001);
        access(1, 0, 3'b101, 9'h002, 32'h0, 32'h80011234, 0);
        chk("lhu_rd", rd, 32'h00008001);

        access(1, 0, 3'b010, 9'h006, 32'h0, 32'h55555555, 0);
        chk("lw_mis_rd", rd, 32'h0);
        access(1, 0, 3'b001, 9'h012, 32'h0, 32'h0000ABCD, 0);
        access(0, 1, 3'b001, 9'h001, 32'h1234, 32'h0, 0);
        chk("sh_mis_rd", rd, 32'h0);

        access(0, 1, 3'b010, 9'h008, 32'hCAFEF00D, 32'h0, 3);
        chk("sw_be", seen_be, 4'b1111);
        chk("sw_wdata", seen_wdata, 32'hCAFEF00D);

        // SW with reset pulsed in its 2nd REQ cycle
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 1; Funct3 = 3'b010; a = 9'h00C; wd = 32'h12345678;
        e_req = 0; e_mis = 0; e_stall = 1;
        @(posedge clk); #1;
        e_req = 1; e_we = 1; e_addr = 9'h00C; e_be = 4'hF; e_wdata = 32'h12345678;
        @(posedge clk); #1;
        chk_en = 0; rst_n = 0; #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_rd", rd, 0);
        MemRead = 0; MemWrite = 0;
        e_req = 0; e_stall = 0; e_rd = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF; chk_en = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        access(1, 0, 3'b010, 9'h004, 32'h0, 32'h0BADF00D, 0);
        chk("post_rst_lw", rd, 32'h0BADF00D);

        access(1, 1, 3'b010, 9'h010, 32'h11111111, 32'hDEADBEEF, 1);
        chk("prio_we", seen_we, 0);
        chk("prio_be", seen_be, 4'b0000);
        chk("prio_rd", rd, 32'hDEADBEEF);

        access(1, 0, 3'b111, 9'h014, 32'h0, 32'h76543210, 0);
        chk("undef_w_rd", rd, 32'h76543210);
        access(0, 1, 3'b001, 9'h012, 32'h0000BEEF, 32'h0, 0);
        chk("sh_be", seen_be, 4'b1100);
        chk("sh_wdata", seen_wdata, 32'hBEEFBEEF);
        chk("store_keeps_rd", rd, 32'h76543210);

        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 32'h00000000;
        @(posedge clk); #1;
        mem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("spurious_ack_rd", rd, 32'h76543210);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
